// File: rtl/md_seq_pkg.sv
// Shared constants and helpers for the multiply/divide sequencer.
package md_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned PROD_W  = 2 * DATA_W;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

  function automatic logic is_div_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // Magnitude of a possibly-signed operand; -2^31 maps to unsigned 0x80000000.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/md_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface md_seq_if;
  import md_seq_pkg::*;

  logic               start;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  operand_1;
  logic [DATA_W-1:0]  operand_2;
  logic               cancel;
  logic               stall_req;
  logic               result_valid;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;
  logic               div_by_zero;

  modport master (
    output start, funct, operand_1, operand_2, cancel,
    input  stall_req, result_valid, hi, lo, div_by_zero
  );

  modport slave (
    input  start, funct, operand_1, operand_2, cancel,
    output stall_req, result_valid, hi, lo, div_by_zero
  );

endinterface

// File: rtl/md_addsub.sv
// Shared 33-bit adder/subtractor; carry=1 on subtract means a >= b.
module md_addsub
  import md_seq_pkg::*;
(
  input  logic [DATA_W:0] a,
  input  logic [DATA_W:0] b,
  input  logic            sub,
  output logic [DATA_W:0] sum,
  output logic            carry
);

  localparam int unsigned W = DATA_W + 1;

  logic [W-1:0] b_eff;

  assign b_eff        = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + (W + 1)'(sub);

endmodule

// File: rtl/md_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: shift-add multiply and restoring
// divide over one shared adder, one iteration per cycle, with pipeline stall.
module md_seq
  import md_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  md_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    counter;
  logic                op_div;
  logic                neg_q;
  logic                neg_r;
  logic [DATA_W-1:0]   opr;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                result_valid_r;
  logic                div_by_zero_r;

  logic                accept_c;
  logic                dbz_c;
  logic                stall_c;
  logic                sgn_c;
  logic                s1_c;
  logic                s2_c;
  logic [DATA_W-1:0]   abs1_c;
  logic [DATA_W-1:0]   abs2_c;
  logic [DATA_W:0]     add_a_c;
  logic [DATA_W:0]     add_b_c;
  logic [DATA_W:0]     add_sum_c;
  logic                add_carry_c;
  logic [PROD_W-1:0]   prod_c;

  md_addsub u_addsub (
    .a     (add_a_c),
    .b     (add_b_c),
    .sub   (op_div),
    .sum   (add_sum_c),
    .carry (add_carry_c)
  );

  // Next state, accept decode and stall request
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    dbz_c      = 1'b0;
    stall_c    = 1'b0;

    if ((state == ST_IDLE || state == ST_DONE) && bus.start && !bus.cancel &&
        is_md_funct(bus.funct)) begin
      accept_c = 1'b1;
      dbz_c    = is_div_funct(bus.funct) && (bus.operand_2 == '0);
    end

    if (bus.cancel) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c)            state_next = dbz_c ? ST_DONE : ST_CALC;
          else                     state_next = ST_IDLE;
        end
        ST_CALC: if (counter == CNT_W'(DATA_W - 1)) state_next = ST_SIGN;
        ST_SIGN:                   state_next = ST_DONE;
        default:                   state_next = ST_IDLE;
      endcase
    end

    stall_c = !bus.cancel &&
              ((accept_c && !dbz_c) || state == ST_CALC || state == ST_SIGN);
  end

  // Operand magnitudes and the per-iteration adder inputs
  always_comb begin
    sgn_c   = is_signed_funct(bus.funct);
    s1_c    = sgn_c & bus.operand_1[DATA_W-1];
    s2_c    = sgn_c & bus.operand_2[DATA_W-1];
    abs1_c  = abs_val(bus.operand_1, sgn_c);
    abs2_c  = abs_val(bus.operand_2, sgn_c);
    prod_c  = {acc_hi, acc_lo};
    add_a_c = '0;
    add_b_c = '0;
    if (op_div) begin
      add_a_c = {acc_hi, acc_lo[DATA_W-1]};
      add_b_c = {1'b0, opr};
    end else begin
      add_a_c = {1'b0, acc_hi};
      add_b_c = acc_lo[0] ? {1'b0, opr} : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath: latch on accept, iterate in CALC, sign-fix and write in SIGN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter        <= '0;
      op_div         <= 1'b0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      opr            <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      hi_r           <= '0;
      lo_r           <= '0;
      result_valid_r <= 1'b0;
      div_by_zero_r  <= 1'b0;
    end else begin
      result_valid_r <= (state_next == ST_DONE);
      if (bus.cancel) begin
        counter <= '0;
      end else if (accept_c) begin
        op_div        <= is_div_funct(bus.funct);
        neg_q         <= s1_c ^ s2_c;
        neg_r         <= s1_c;
        counter       <= '0;
        acc_hi        <= '0;
        div_by_zero_r <= dbz_c;
        if (is_div_funct(bus.funct)) begin
          acc_lo <= abs1_c;
          opr    <= abs2_c;
        end else begin
          acc_lo <= abs2_c;
          opr    <= abs1_c;
        end
        if (dbz_c) begin
          hi_r <= bus.operand_1;
          lo_r <= '1;
        end
      end else if (state == ST_CALC) begin
        counter <= counter + CNT_W'(1);
        if (op_div) begin
          acc_hi <= add_carry_c ? add_sum_c[DATA_W-1:0] : add_a_c[DATA_W-1:0];
          acc_lo <= {acc_lo[DATA_W-2:0], add_carry_c};
        end else begin
          acc_hi <= add_sum_c[DATA_W:1];
          acc_lo <= {add_sum_c[0], acc_lo[DATA_W-1:1]};
        end
      end else if (state == ST_SIGN) begin
        if (op_div) begin
          lo_r <= neg_q ? DATA_W'(-acc_lo) : acc_lo;
          hi_r <= neg_r ? DATA_W'(-acc_hi) : acc_hi;
        end else begin
          {hi_r, lo_r} <= neg_q ? PROD_W'(-prod_c) : prod_c;
        end
      end
    end
  end

  assign bus.stall_req    = stall_c;
  assign bus.result_valid = result_valid_r;
  assign bus.hi           = hi_r;
  assign bus.lo           = lo_r;
  assign bus.div_by_zero  = div_by_zero_r;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: vector table of operations plus cancel/reset/busy sequences.
module tb_md_seq;
  import md_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  md_seq_if bus();

  md_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.funct     = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.cancel    = 1'b0;
  endtask

  // Issue one operation and follow it to its result; optional start injected mid-run.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int elat, input int inject_at, input string tag);
    int lat;
    int stalls;
    @(negedge clk);
    bus.start = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    #1;
    check({tag, " stall_at_accept"}, 64'(bus.stall_req), 64'(!edbz));
    @(negedge clk);
    idle_inputs();
    lat = 0;
    stalls = 0;
    while (!bus.result_valid && lat < 200) begin
      if (bus.stall_req) stalls++;
      if (lat == inject_at) begin
        bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.operand_1 = 32'd2; bus.operand_2 = 32'd3;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      lat++;
    end
    idle_inputs();
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(elat));
    check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
    check({tag, " stall_in_done"}, 64'(bus.stall_req), 64'(0));
    @(negedge clk);
    check({tag, " valid_pulse"}, 64'(bus.result_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[1]  = '{FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[2]  = '{FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{FUNCT_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[4]  = '{FUNCT_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0};
    vecs[5]  = '{FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
    vecs[6]  = '{FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 33};
    vecs[7]  = '{FUNCT_MULT,  32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
    vecs[8]  = '{FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[9]  = '{FUNCT_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[10] = '{FUNCT_DIV,   32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1, 0};
    vecs[11] = '{FUNCT_MULTU, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 1'b0, 33};
    vecs[12] = '{FUNCT_DIVU,  32'd3,         32'd5,         32'd3,         32'd0,         1'b0, 33};

    idle_inputs();
    rst = 1'b1;
    #12;
    check("reset stall_req", 64'(bus.stall_req), 64'(0));
    check("reset result_valid", 64'(bus.result_valid), 64'(0));
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Unknown funct with start must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.funct = 6'h20; bus.operand_1 = 32'd9; bus.operand_2 = 32'd3;
    #1;
    check("bad_funct stall", 64'(bus.stall_req), 64'(0));
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("bad_funct valid", 64'(bus.result_valid), 64'(0));
    check("bad_funct lo", 64'(bus.lo), 64'(0));

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
             vecs[i].lat, -1, $sformatf("vec%0d", i));

    // Cancel at counter=10: no result, hi/lo keep vec12's values, then a fresh op
    @(negedge clk);
    bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.operand_1 = 32'd2; bus.operand_2 = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    #1;
    check("cancel stall_drop", 64'(bus.stall_req), 64'(0));
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel valid", 64'(bus.result_valid), 64'(0));
    check("cancel stall_after", 64'(bus.stall_req), 64'(0));
    check("cancel hi_kept", 64'(bus.hi), 64'(3));
    check("cancel lo_kept", 64'(bus.lo), 64'(0));
    run_op(FUNCT_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 33, -1, "after_cancel");

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.funct = FUNCT_DIV; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7;
    @(negedge clk);
    idle_inputs();
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst stall_req", 64'(bus.stall_req), 64'(0));
    check("midrst result_valid", 64'(bus.result_valid), 64'(0));
    check("midrst hi", 64'(bus.hi), 64'(0));
    check("midrst lo", 64'(bus.lo), 64'(0));
    check("midrst div_by_zero", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Start raised during CALC is ignored; the divide completes unchanged
    run_op(FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 5, "busy_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
